// File: rtl/sram_burst_reader.sv
// sram_burst_reader
// Read engine for a single-port synchronous SRAM with a 1-cycle read latency.
// It accepts a burst command (base address and length), issues sequential
// SRAM reads, and returns the words as a valid/ready stream. The final beat
// of the burst carries a last flag. The engine never writes to the SRAM.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   start, base_addr,     burst request; sampled only while busy=0
//   burst_len
//   busy, done            burst in progress / one-cycle completion pulse
//   sram_en, sram_we,     SRAM read strobe and address; we and wdata are
//   sram_addr,            tied to 0
//   sram_wdata
//   sram_rdata            registered SRAM read data
//   m_valid, m_ready,     output stream (head of the internal FIFO)
//   m_data, m_last
module sram_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] addr_ptr, addr_ptr_next, sram_addr_next;
    logic [LEN_WIDTH-1:0]  issue_cnt, issue_cnt_next, beat_cnt;
    logic                  sram_en_next, done_next;
    logic                  rd_tag;

    logic [DATA_WIDTH:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      fifo_cnt;
    logic                  push, pop;
    logic [CNT_W:0]        inflight;
    logic                  credit_ok;

    assign sram_we    = 1'b0;
    assign sram_wdata = '0;
    assign busy       = (state != IDLE);

    assign m_valid          = (fifo_cnt != '0);
    assign {m_last, m_data} = fifo_mem[rd_ptr];
    assign pop              = m_valid & m_ready;
    assign push             = rd_tag;

    // Every word that will end up in the FIFO is counted: the read presented
    // this cycle (sram_en), the word returning this cycle (rd_tag), and the
    // stored entries. A pop in the same cycle is deliberately not counted as
    // free space, which keeps the issue decision off the m_ready path.
    assign inflight  = {1'b0, fifo_cnt} + (CNT_W+1)'(sram_en) + (CNT_W+1)'(rd_tag);
    assign credit_ok = (inflight < (CNT_W+1)'(FIFO_DEPTH));

    // Next-state and registered-output decode. The first read is issued
    // directly from IDLE, so sram_en is high in the cycle after start is
    // accepted.
    always_comb begin
        state_next     = state;
        sram_en_next   = 1'b0;
        sram_addr_next = sram_addr;
        addr_ptr_next  = addr_ptr;
        issue_cnt_next = issue_cnt;
        done_next      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (burst_len == '0) begin
                        done_next = 1'b1;
                    end else begin
                        sram_en_next   = 1'b1;
                        sram_addr_next = base_addr;
                        addr_ptr_next  = base_addr + 1'b1;
                        issue_cnt_next = burst_len - 1'b1;
                        state_next     = (burst_len == LEN_WIDTH'(1)) ? DRAIN : ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (credit_ok) begin
                    sram_en_next   = 1'b1;
                    sram_addr_next = addr_ptr;
                    addr_ptr_next  = addr_ptr + 1'b1;
                    issue_cnt_next = issue_cnt - 1'b1;
                    if (issue_cnt == LEN_WIDTH'(1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control registers. rd_tag delays sram_en by one cycle, so it marks the
    // cycle in which sram_rdata holds the word requested by a real issue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sram_en   <= 1'b0;
            sram_addr <= '0;
            addr_ptr  <= '0;
            issue_cnt <= '0;
            done      <= 1'b0;
            rd_tag    <= 1'b0;
        end else begin
            state     <= state_next;
            sram_en   <= sram_en_next;
            sram_addr <= sram_addr_next;
            addr_ptr  <= addr_ptr_next;
            issue_cnt <= issue_cnt_next;
            done      <= done_next;
            rd_tag    <= sram_en;
        end
    end

    // Output FIFO. Each entry stores the data and its last flag. beat_cnt
    // counts the words still to be captured, so the entry written while
    // beat_cnt==1 is the final beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            beat_cnt <= '0;
        end else begin
            if (state == IDLE && start && burst_len != '0) begin
                beat_cnt <= burst_len;
            end else if (push) begin
                beat_cnt <= beat_cnt - 1'b1;
            end
            if (push) begin
                fifo_mem[wr_ptr] <= {(beat_cnt == LEN_WIDTH'(1)), sram_rdata};
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_burst_reader.sv
// tb_sram_burst_reader
// Directed testbench for sram_burst_reader. The SRAM model returns the low
// address byte as data, one clock after the address is presented, and it
// updates sram_rdata on every clock. Inputs change 1 time unit after the
// rising edge. A monitor samples the DUT on the falling edge.
module tb_sram_burst_reader;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int LW = 16;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] burst_len = '0;
    logic          busy, done, sram_en, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata = '0;
    logic          m_valid, m_last;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;

    int tests = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;

    logic [7:0]  beat_data [$];
    logic        beat_last [$];
    logic [15:0] addr_q [$];
    int en_cnt, pop_cnt, done_cnt, valid_cnt, we_cnt;
    int first_valid_cyc, last_pop_cyc, done_cyc;

    sram_burst_reader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .burst_len(burst_len), .busy(busy), .done(done), .sram_en(sram_en),
        .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: registered read, updated every clock, data = address low byte
    always @(posedge clk) sram_rdata <= sram_addr[7:0];

    // Monitor: records issues, handshakes and done pulses, and checks that the
    // number of outstanding words never exceeds the FIFO depth
    always @(negedge clk) begin
        if (sram_we) we_cnt++;
        if (sram_en) begin
            en_cnt++;
            addr_q.push_back(sram_addr);
        end
        if (reset_n) begin
            tests++;
            assert ((en_cnt - pop_cnt) <= FD) else begin
                failures++;
                $error("FAIL overflow_guard observed=%0d expected<=%0d", en_cnt - pop_cnt, FD);
            end
        end
        if (m_valid) begin
            if (valid_cnt == 0) first_valid_cyc = cyc;
            valid_cnt++;
        end
        if (m_valid && m_ready) begin
            beat_data.push_back(m_data);
            beat_last.push_back(m_last);
            pop_cnt++;
            last_pop_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic clearMon();
        beat_data.delete();
        beat_last.delete();
        addr_q.delete();
        en_cnt = 0; pop_cnt = 0; done_cnt = 0; valid_cnt = 0; we_cnt = 0;
        first_valid_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
    endtask

    // Presents a command for one cycle and returns just after the edge that samples it
    task automatic applyStimulus(input logic [15:0] base, input logic [15:0] len);
        start     = 1'b1;
        base_addr = base;
        burst_len = len;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (!done && n < max_cycles) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    task automatic checkBurst(input string tag, input logic [15:0] base, input int len);
        logic [15:0] a;
        checkOutput({tag, "_beats"}, 32'(beat_data.size()), 32'(len));
        checkOutput({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        for (int i = 0; i < len && i < beat_data.size(); i++) begin
            a = base + 16'(i);
            checkOutput($sformatf("%s_data%0d", tag, i), 32'(beat_data[i]), 32'(a[7:0]));
            checkOutput($sformatf("%s_last%0d", tag, i), 32'(beat_last[i]), 32'(i == len - 1));
        end
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  head;
        int n;
        clearMon();

        // Reset state
        repeat (2) tick();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_sram_en", 32'(sram_en), 32'd0);
        checkOutput("rst_sram_we", 32'(sram_we), 32'd0);
        checkOutput("rst_sram_addr", 32'(sram_addr), 32'd0);
        checkOutput("rst_sram_wdata", 32'(sram_wdata), 32'd0);
        checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_m_last", 32'(m_last), 32'd0);
        checkOutput("rst_m_data", 32'(m_data), 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Basic burst: base 0x0010, length 4, no backpressure
        clearMon();
        m_ready = 1'b1;
        applyStimulus(16'h0010, 16'd4);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        checkOutput("t1_sram_en", 32'(sram_en), 32'd1);
        checkOutput("t1_sram_addr", 32'(sram_addr), 32'h0010);
        tick();
        checkOutput("t1_valid_e1", 32'(m_valid), 32'd0);
        tick();
        checkOutput("t1_valid_e2", 32'(m_valid), 32'd1);
        checkOutput("t1_data_e2", 32'(m_data), 32'h10);
        waitDone("t1_done_seen", 20);
        checkOutput("t1_busy_at_done", 32'(busy), 32'd0);
        tick();
        checkOutput("t1_done_pulse", 32'(done), 32'd0);
        checkOutput("t1_first_valid", 32'(first_valid_cyc), 32'(start_cyc + 3));
        checkOutput("t1_done_after_last", 32'(done_cyc), 32'(last_pop_cyc + 1));
        checkOutput("t1_n_plus_3", 32'(done_cyc), 32'(start_cyc + 7));
        checkBurst("t1", 16'h0010, 4);

        // Address wrap: base 0xFFFE, length 4
        clearMon();
        applyStimulus(16'hFFFE, 16'd4);
        waitDone("t2_done_seen", 20);
        tick();
        checkOutput("t2_issues", 32'(addr_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
            a = 16'hFFFE + 16'(i);
            checkOutput($sformatf("t2_addr%0d", i), 32'(addr_q[i]), 32'(a));
        end
        checkBurst("t2", 16'hFFFE, 4);

        // Backpressure: m_ready toggles for 8 cycles, then is held low for 10 cycles
        clearMon();
        applyStimulus(16'h0040, 16'd16);
        for (int i = 0; i < 8; i++) begin
            m_ready = (i % 2 == 0);
            tick();
        end
        m_ready = 1'b0;
        head = 8'h40 + 8'(pop_cnt);
        checkOutput("t3_valid_hold", 32'(m_valid), 32'd1);
        checkOutput("t3_head_hold_start", 32'(m_data), 32'(head));
        repeat (10) tick();
        checkOutput("t3_head_hold_end", 32'(m_data), 32'(head));
        checkOutput("t3_en_stalled", 32'(sram_en), 32'd0);
        checkOutput("t3_outstanding", 32'(en_cnt - pop_cnt), 32'(FD));
        m_ready = 1'b1;
        waitDone("t3_done_seen", 60);
        tick();
        checkOutput("t3_issues", 32'(en_cnt), 32'd16);
        checkBurst("t3", 16'h0040, 16);

        // Zero-length command
        clearMon();
        applyStimulus(16'h1234, 16'd0);
        checkOutput("t4_done", 32'(done), 32'd1);
        checkOutput("t4_busy", 32'(busy), 32'd0);
        tick();
        checkOutput("t4_done_pulse", 32'(done), 32'd0);
        tick();
        checkOutput("t4_no_issue", 32'(en_cnt), 32'd0);
        checkOutput("t4_no_valid", 32'(valid_cnt), 32'd0);
        checkOutput("t4_done_cnt", 32'(done_cnt), 32'd1);

        // A start while busy is ignored
        clearMon();
        applyStimulus(16'h0080, 16'd3);
        tick();
        start     = 1'b1;
        base_addr = 16'h0090;
        burst_len = 16'd5;
        tick();
        start = 1'b0;
        waitDone("t5_done_seen", 20);
        repeat (6) tick();
        checkOutput("t5_issues", 32'(en_cnt), 32'd3);
        checkOutput("t5_busy_after", 32'(busy), 32'd0);
        checkBurst("t5", 16'h0080, 3);

        // Reset mid-burst after two beats, then a fresh burst
        clearMon();
        applyStimulus(16'h0020, 16'd8);
        n = 0;
        while (pop_cnt < 2 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("t6_two_beats", 32'(pop_cnt >= 2), 32'd1);
        #2;
        reset_n = 1'b0;
        clearMon();
        #1;
        checkOutput("t6_rst_busy", 32'(busy), 32'd0);
        checkOutput("t6_rst_sram_en", 32'(sram_en), 32'd0);
        checkOutput("t6_rst_sram_addr", 32'(sram_addr), 32'd0);
        checkOutput("t6_rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("t6_rst_m_data", 32'(m_data), 32'd0);
        checkOutput("t6_rst_m_last", 32'(m_last), 32'd0);
        checkOutput("t6_rst_done", 32'(done), 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        checkOutput("t6_no_done", 32'(done_cnt), 32'd0);
        clearMon();
        applyStimulus(16'h0030, 16'd3);
        waitDone("t6_done_seen", 20);
        tick();
        checkBurst("t6", 16'h0030, 3);
        checkOutput("t6_never_write", 32'(we_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
